// File: rtl/stb_seq_ctrl_if.sv
// Generator-side bundle for stb_seq_ctrl.
// master: controller (drives gen_arst_o/gen_run_det_o/gen_oe_o); slave: strobe generator.
interface stb_seq_ctrl_if #(
    parameter int T_CNT_WIDTH = 32
);
    logic                   gen_rdy_i;
    logic                   gen_err_i;
    logic                   gen_stb_i;
    logic [T_CNT_WIDTH-1:0] gen_period_i;
    logic                   gen_arst_o;
    logic                   gen_run_det_o;
    logic                   gen_oe_o;

    modport master (
        input  gen_rdy_i,
        input  gen_err_i,
        input  gen_stb_i,
        input  gen_period_i,
        output gen_arst_o,
        output gen_run_det_o,
        output gen_oe_o
    );

    modport slave (
        output gen_rdy_i,
        output gen_err_i,
        output gen_stb_i,
        output gen_period_i,
        input  gen_arst_o,
        input  gen_run_det_o,
        input  gen_oe_o
    );
endinterface

// File: rtl/stb_seq_ctrl.sv
// Strobe generator sequencer: reset, trigger, lock on period, then gate strobe.
// Ports: clk_i, arstn_i (async low), start_i, stop_i, out_en_i, gen (generator
// bundle, master side), stb_o, period_o, busy_o, locked_o, done_o, err_o, err_code_o.
// Optional: define STB_SEQ_CTRL_RETRY_EN to retry up to RETRY_MAX times on timeout.
module stb_seq_ctrl #(
    parameter int T_CNT_WIDTH    = 32,
    parameter int RST_CYCLES     = 4,
    parameter int RUN_HOLD       = 4,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int MIN_PERIOD     = 10,
    parameter int MAX_PERIOD     = 1000000,
    parameter int RETRY_MAX      = 2
) (
    input  logic                   clk_i,
    input  logic                   arstn_i,
    input  logic                   start_i,
    input  logic                   stop_i,
    input  logic                   out_en_i,
    stb_seq_ctrl_if.master         gen,
    output logic                   stb_o,
    output logic [T_CNT_WIDTH-1:0] period_o,
    output logic                   busy_o,
    output logic                   locked_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic [1:0]             err_code_o
);

    typedef enum logic [2:0] {
        IDLE,
        GEN_RST,
        WAIT_RDY,
        TRIG,
        WAIT_LOCK,
        CHECK,
        RUN,
        FAIL
    } state_t;

    localparam int HOLD_MAX = (RST_CYCLES > RUN_HOLD) ? RST_CYCLES : RUN_HOLD;
    localparam int CW = $clog2(HOLD_MAX + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(RUN_HOLD - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [T_CNT_WIDTH-1:0] P_MIN = T_CNT_WIDTH'(MIN_PERIOD);
    localparam logic [T_CNT_WIDTH-1:0] P_MAX = T_CNT_WIDTH'(MAX_PERIOD);

    localparam logic [1:0] E_TMO   = 2'd1;
    localparam logic [1:0] E_RANGE = 2'd2;
    localparam logic [1:0] E_GEN   = 2'd3;

    state_t          state;
    state_t          nxt;
    logic [CW-1:0]   cnt;
    logic [TW-1:0]   tmo;
    logic            stb_q;
    logic            stb_rise;
    logic            in_range;
    logic            tmo_fire;
    logic [1:0]      code_n;

`ifdef STB_SEQ_CTRL_RETRY_EN
    localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
    localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);
    logic [RW-1:0] retry;
`else
    logic unused_retry;
    assign unused_retry = (RETRY_MAX != 0);
`endif

    assign stb_rise = gen.gen_stb_i & ~stb_q;
    assign in_range = (period_o >= P_MIN) && (period_o <= P_MAX);

    // Combinational strobe gate; drops immediately when reset forces IDLE.
    assign stb_o = (state == RUN) & gen.gen_stb_i & out_en_i;

    always_comb begin
        nxt      = state;
        code_n   = err_code_o;
        tmo_fire = 1'b0;
        if (stop_i && (state != IDLE)) begin
            nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        nxt    = GEN_RST;
                        code_n = 2'd0;
                    end
                end
                GEN_RST: begin
                    if (cnt == RST_LAST) nxt = WAIT_RDY;
                end
                WAIT_RDY: begin
                    if (gen.gen_rdy_i) nxt = TRIG;
                    else if (tmo == TMO_LAST) tmo_fire = 1'b1;
                end
                TRIG: begin
                    if (cnt == HOLD_LAST) nxt = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (gen.gen_err_i) begin
                        nxt    = FAIL;
                        code_n = E_GEN;
                    end else if (tmo == TMO_LAST) begin
                        tmo_fire = 1'b1;
                    end else if (stb_rise) begin
                        nxt = CHECK;
                    end
                end
                CHECK: begin
                    if (in_range) begin
                        nxt = RUN;
                    end else begin
                        nxt    = FAIL;
                        code_n = E_RANGE;
                    end
                end
                RUN: begin
                    if (gen.gen_err_i) begin
                        nxt    = FAIL;
                        code_n = E_GEN;
                    end
                end
                FAIL: begin
                    if (start_i) begin
                        nxt    = GEN_RST;
                        code_n = 2'd0;
                    end
                end
                default: nxt = IDLE;
            endcase

            if (tmo_fire) begin
`ifdef STB_SEQ_CTRL_RETRY_EN
                if (retry < RETRY_LIM) begin
                    nxt = GEN_RST;
                end else begin
                    nxt    = FAIL;
                    code_n = E_TMO;
                end
`else
                nxt    = FAIL;
                code_n = E_TMO;
`endif
            end
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state             <= IDLE;
            cnt               <= '0;
            tmo               <= '0;
            stb_q             <= 1'b0;
            period_o          <= '0;
            gen.gen_arst_o    <= 1'b1;
            gen.gen_run_det_o <= 1'b0;
            gen.gen_oe_o      <= 1'b0;
            busy_o            <= 1'b0;
            locked_o          <= 1'b0;
            done_o            <= 1'b0;
            err_o             <= 1'b0;
            err_code_o        <= 2'd0;
        end else begin
            state <= nxt;
            stb_q <= gen.gen_stb_i;

            // Hold counter restarts on every state change.
            if (nxt != state) cnt <= '0;
            else if ((state == GEN_RST) || (state == TRIG)) cnt <= cnt + 1'b1;

            if (nxt != state) tmo <= '0;
            else if ((state == WAIT_RDY) || (state == WAIT_LOCK)) tmo <= tmo + 1'b1;

            if ((state == WAIT_LOCK) && (nxt == CHECK)) period_o <= gen.gen_period_i;

            // Outputs follow the next state so they line up with it.
            gen.gen_arst_o    <= (nxt == IDLE) || (nxt == GEN_RST) || (nxt == FAIL);
            gen.gen_run_det_o <= (nxt == TRIG);
            gen.gen_oe_o      <= (nxt == WAIT_LOCK) || (nxt == CHECK) || (nxt == RUN);
            busy_o            <= (nxt != IDLE) && (nxt != FAIL);
            locked_o          <= (nxt == RUN);
            done_o            <= (state == CHECK) && (nxt == RUN);
            err_o             <= (nxt == FAIL);
            err_code_o        <= code_n;
        end
    end

`ifdef STB_SEQ_CTRL_RETRY_EN
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            retry <= '0;
        end else if (nxt == GEN_RST) begin
            if ((state == IDLE) || (state == FAIL)) retry <= '0;
            else if (state != GEN_RST) retry <= retry + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_stb_seq_ctrl.sv
// Self-checking bench for stb_seq_ctrl with a simple strobe generator model.
// Table of period scenarios through a scoreboard, plus timeout/stop/reset sequences.
module tb_stb_seq_ctrl;
    localparam int W = 32;

    logic clk = 1'b0;
    logic arstn = 1'b0;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic out_en = 1'b0;
    logic stb;
    logic busy;
    logic locked;
    logic done;
    logic err;
    logic [1:0] code;
    logic [W-1:0] period;

    int checks = 0;
    int errors = 0;

    stb_seq_ctrl_if #(.T_CNT_WIDTH(W)) g ();

    stb_seq_ctrl #(
        .T_CNT_WIDTH(W),
        .RST_CYCLES(4),
        .RUN_HOLD(4),
        .TIMEOUT_CYCLES(1000),
        .MIN_PERIOD(10),
        .MAX_PERIOD(1000),
        .RETRY_MAX(2)
    ) dut (
        .clk_i(clk),
        .arstn_i(arstn),
        .start_i(start),
        .stop_i(stop),
        .out_en_i(out_en),
        .gen(g),
        .stb_o(stb),
        .period_o(period),
        .busy_o(busy),
        .locked_o(locked),
        .done_o(done),
        .err_o(err),
        .err_code_o(code)
    );

    always #5 clk = ~clk;

    // Generator model: ready once out of reset, square-wave strobe when enabled.
    bit stb_en = 1'b0;
    int ph = 0;
    always begin
        @(posedge clk);
        #2;
        g.gen_rdy_i = ~g.gen_arst_o;
        ph = ph + 1;
        g.gen_stb_i = stb_en && ((ph % 8) < 4);
    end

    typedef struct {
        int         per;
        bit         inject;
        logic [1:0] exp_code;
        bit         exp_locked;
        int         exp_done;
    } vec_t;

    typedef struct {
        logic [1:0] code;
        bit         err;
        bit         locked;
        int         per;
        int         done;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic run_case(input vec_t v);
        exp_t x;
        int arst_n;
        int det_n;
        int done_n;
        bit hit;
        arst_n = 0;
        det_n = 0;
        done_n = 0;
        hit = 1'b0;
        stb_en = 1'b1;
        out_en = 1'b1;
        g.gen_period_i = W'(v.per);
        pulse_start();
        sb.push_back('{code: v.exp_code, err: (v.exp_code != 2'd0),
                       locked: v.exp_locked, per: v.per, done: v.exp_done});
        for (int k = 0; k < 300 && !hit; k++) begin
            if (busy && g.gen_arst_o) arst_n++;
            if (g.gen_run_det_o) det_n++;
            if (done) done_n++;
            if (locked || err) hit = 1'b1;
            else @(negedge clk);
        end
        if (!hit) begin
            errors++;
            $display("FAIL wait_terminal: no lock/err for period %0d", v.per);
        end
        if (hit && locked && !v.inject) begin
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                out_en = (i < 8);
                #1;
                if (done) done_n++;
                chk("stb_follow", stb, g.gen_stb_i & out_en);
            end
        end
        if (hit && locked && v.inject) begin
            g.gen_err_i = 1'b1;
            @(negedge clk);
            g.gen_err_i = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) done_n++;
        end
        x = sb.pop_front();
        chk("arst_cycles", arst_n, 4);
        chk("run_det_cycles", det_n, 4);
        chk("done_pulses", done_n, x.done);
        chk("period_o", period, x.per);
        chk("err_code", code, x.code);
        chk("err_o", err, x.err);
        chk("locked_o", locked, x.locked);
        if (x.err) begin
            chk("stb_in_fail", stb, 0);
            chk("busy_in_fail", busy, 0);
        end
        pulse_stop();
        chk("idle_busy", busy, 0);
        chk("idle_err", err, 0);
    endtask

    vec_t tbl[7];

    initial begin
        int ep;
        int exp_ep;
        bit prev;
        bit hit;

        tbl[0] = '{per: 100,  inject: 0, exp_code: 2'd0, exp_locked: 1, exp_done: 1};
        tbl[1] = '{per: 5,    inject: 0, exp_code: 2'd2, exp_locked: 0, exp_done: 0};
        tbl[2] = '{per: 9,    inject: 0, exp_code: 2'd2, exp_locked: 0, exp_done: 0};
        tbl[3] = '{per: 10,   inject: 0, exp_code: 2'd0, exp_locked: 1, exp_done: 1};
        tbl[4] = '{per: 1000, inject: 0, exp_code: 2'd0, exp_locked: 1, exp_done: 1};
        tbl[5] = '{per: 1001, inject: 0, exp_code: 2'd2, exp_locked: 0, exp_done: 0};
        tbl[6] = '{per: 100,  inject: 1, exp_code: 2'd3, exp_locked: 0, exp_done: 1};

        g.gen_rdy_i = 1'b0;
        g.gen_err_i = 1'b0;
        g.gen_stb_i = 1'b0;
        g.gen_period_i = '0;

        repeat (3) @(negedge clk);
        chk("rst_arst", g.gen_arst_o, 1);
        chk("rst_busy", busy, 0);
        chk("rst_locked", locked, 0);
        chk("rst_err", {err, code}, 0);
        chk("rst_period", period, 0);
        chk("rst_misc", {stb, done, g.gen_oe_o, g.gen_run_det_o}, 0);
        arstn = 1'b1;
        repeat (2) @(negedge clk);

        foreach (tbl[i]) run_case(tbl[i]);

        // Timeout: generator never produces a strobe edge.
`ifdef STB_SEQ_CTRL_RETRY_EN
        exp_ep = 3;
`else
        exp_ep = 1;
`endif
        stb_en = 1'b0;
        pulse_start();
        ep = 0;
        prev = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 6000 && !hit; k++) begin
            if ((busy && g.gen_arst_o) && !prev) ep++;
            prev = busy && g.gen_arst_o;
            if (err) hit = 1'b1;
            else @(negedge clk);
        end
        if (!hit) begin
            errors++;
            $display("FAIL timeout_wait: err_o never rose");
        end
        chk("tmo_episodes", ep, exp_ep);
        chk("tmo_code", code, 1);
        pulse_stop();

        // Stop in the middle of WAIT_LOCK.
        pulse_start();
        hit = 1'b0;
        for (int k = 0; k < 100 && !hit; k++) begin
            if (g.gen_oe_o) hit = 1'b1;
            else @(negedge clk);
        end
        if (!hit) begin
            errors++;
            $display("FAIL wait_lock_entry: gen_oe_o never rose");
        end
        repeat (3) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_busy", busy, 0);
        chk("stop_oe", g.gen_oe_o, 0);
        chk("stop_run_det", g.gen_run_det_o, 0);
        chk("stop_arst", g.gen_arst_o, 1);

        // Asynchronous reset while running.
        stb_en = 1'b1;
        out_en = 1'b1;
        g.gen_period_i = W'(100);
        pulse_start();
        hit = 1'b0;
        for (int k = 0; k < 300 && !hit; k++) begin
            if (locked && stb) hit = 1'b1;
            else @(negedge clk);
        end
        if (!hit) begin
            errors++;
            $display("FAIL run_wait: no running strobe before reset");
        end
        #2;
        arstn = 1'b0;
        #1;
        chk("arst_stb", stb, 0);
        chk("arst_gen_arst", g.gen_arst_o, 1);
        chk("arst_locked", locked, 0);
        chk("arst_period", period, 0);
        @(negedge clk);
        arstn = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stb_seq_ctrl.md
STB_SEQ_CTRL -- requirements
Module: stb_seq_ctrl

Interface
REQ-001 SHALL have parameter T_CNT_WIDTH, default 32, width of the period bus.
REQ-002 SHALL have parameter RST_CYCLES, default 4, number of cycles gen_arst_o is held in GEN_RST.
REQ-003 SHALL have parameter RUN_HOLD, default 4 (minimum 3), number of cycles gen_run_det_o is held high.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1000000, per-phase wait limit.
REQ-005 SHALL have parameters MIN_PERIOD, default 10, and MAX_PERIOD, default 1000000, which bound the accepted period inclusively.
REQ-006 SHALL have parameter RETRY_MAX, default 2, number of extra attempts after a timeout.
REQ-007 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-008 SHALL have port arstn_i, input, 1 bit: reset, asynchronous and active-low.
REQ-009 SHALL have port start_i, input, 1 bit: start-measurement request.
REQ-010 SHALL have port stop_i, input, 1 bit: abort/stop request.
REQ-011 SHALL have port out_en_i, input, 1 bit: strobe output enable.
REQ-012 SHALL have ports gen_rdy_i, gen_err_i and gen_stb_i, inputs, 1 bit each, driven by the strobe generator.
REQ-013 SHALL have port gen_period_i, input, T_CNT_WIDTH bits: the generator's measured period.
REQ-014 SHALL have ports gen_arst_o, gen_run_det_o and gen_oe_o, outputs, 1 bit each, driving the generator.
REQ-015 SHALL have port stb_o, output, 1 bit: gated strobe.
REQ-016 SHALL have port period_o, output, T_CNT_WIDTH bits: captured period.
REQ-017 SHALL have ports busy_o, locked_o, done_o and err_o, outputs, 1 bit each; err_code_o, output, 2 bits.

Function
REQ-018 SHALL implement the states IDLE, GEN_RST, WAIT_RDY, TRIG, WAIT_LOCK, CHECK, RUN and FAIL.
REQ-019 SHALL, in IDLE, on start_i go to GEN_RST and clear the retry count; SHALL ignore start_i in every other state except FAIL.
REQ-020 SHALL, in GEN_RST, hold gen_arst_o=1 for RST_CYCLES cycles, then go to WAIT_RDY.
REQ-021 SHALL, in WAIT_RDY, go to TRIG when gen_rdy_i=1.
REQ-022 SHALL, in TRIG, hold gen_run_det_o=1 for RUN_HOLD cycles, then go to WAIT_LOCK.
REQ-023 SHALL, in WAIT_LOCK, register period_o from gen_period_i and go to CHECK on a gen_stb_i rising edge (previous-sample register, same clock, no synchronizer).
REQ-024 SHALL, in CHECK (1 cycle), go to RUN and pulse done_o for exactly 1 cycle if MIN_PERIOD <= period_o <= MAX_PERIOD; otherwise go to FAIL with err_code 2.
REQ-025 SHALL, in RUN, drive locked_o=1 and stb_o = gen_stb_i AND out_en_i (combinational); stb_o SHALL be 0 in all other states.
REQ-026 SHALL, on gen_err_i=1 in WAIT_LOCK or RUN, go to FAIL with err_code 3.
REQ-027 SHALL clear a timeout counter on entry to WAIT_RDY and WAIT_LOCK; reaching TIMEOUT_CYCLES SHALL be a timeout (err_code 1).
REQ-028 SHALL drive gen_oe_o=1 only in WAIT_LOCK, CHECK and RUN, and gen_arst_o=1 in IDLE, GEN_RST and FAIL.
REQ-029 SHALL have busy_o=1 in every state except IDLE and FAIL; err_o=1 only in FAIL; err_code_o held until the next start_i.
REQ-030 SHALL, on stop_i in any non-IDLE state, go to IDLE on the next cycle with highest priority (over start_i, timeout and gen_err_i).
REQ-031 SHALL, in FAIL, go to GEN_RST on start_i (clearing err_o and err_code_o) and to IDLE on stop_i.

Reset
REQ-032 SHALL, while arstn_i=0, immediately force state IDLE, gen_arst_o=1, all other outputs and all counters 0, and period_o=0.
REQ-033 SHALL, on reset mid-RUN, deassert stb_o and locked_o asynchronously.

Configuration
REQ-034 SHALL, with STB_SEQ_CTRL_RETRY_EN defined, on a timeout with retry count < RETRY_MAX increment the count and go to GEN_RST, and otherwise go to FAIL with err_code 1.
REQ-035 SHALL, without STB_SEQ_CTRL_RETRY_EN, go to FAIL with err_code 1 on the first timeout, and SHALL implement no retry counter.

Verification (RST_CYCLES=4, RUN_HOLD=4, TIMEOUT_CYCLES=1000, MIN=10, MAX=1000, RETRY_MAX=2)
REQ-036 SHALL cover: generator model with period 100, start_i pulse -> gen_arst_o high 4 cycles, gen_run_det_o high 4 cycles, period_o=100, one done_o pulse, locked_o=1, stb_o follows gen_stb_i while out_en_i=1.
REQ-037 SHALL cover: model period 5 -> FAIL, err_o=1, err_code_o=2, stb_o=0.
REQ-038 SHALL cover: no gen_stb_i edge -> with macro 3 gen_arst_o episodes then err_code_o=1; without macro 1 episode then err_code_o=1.
REQ-039 SHALL cover: stop_i asserted mid-WAIT_LOCK -> IDLE next cycle, gen_oe_o=0, gen_run_det_o=0, busy_o=0.
REQ-040 SHALL cover: gen_err_i=1 in RUN -> FAIL, err_code_o=3, locked_o=0.
REQ-041 SHALL cover: arstn_i low mid-RUN -> stb_o=0, gen_arst_o=1 without waiting for a clock edge.
